regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised CPU integer register file with NRD synchronous read ports and one write port. Register x0 is hard-wired to zero, and a write-to-read bypass is selectable by parameter. An integrated scoreboard holds one pending-write bit per register. After reset, a clear sweep zeroes storage one register per cycle so the array maps to RAM. Sits between decode (read/issue) and writeback (write) in the pipeline.

Parameters:
XLEN, 32, data width of each register
NREG, 16, number of architectural registers (power of two, >=2); derived AW = clog2(NREG)
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to reads and hazards; 0 = no forwarding

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
init_done  out  1  high once clear sweep finished; ports are live only when high
we  in  1  write enable (writeback)
waddr  in  AW  write register index
wdata  in  XLEN  write data
re  in  1  read enable, common to all read ports
raddr  in  NRD*AW  packed read indices, port p at [p*AW +: AW]
rdata  out  NRD*XLEN  packed registered read data, port p at [p*XLEN +: XLEN]
issue_valid  in  1  an instruction writing issue_rd has issued
issue_rd  in  AW  destination register of the issued instruction
pending  out  NREG  scoreboard bits, bit 0 always 0
hazard  out  NRD  combinational, port p reads a register with an outstanding write

Behaviour:
- Reset applies while reset=1 on a clk edge:
  - init_done=0, rdata=0, pending=0.
  - FSM enters CLEAR with sweep index 1.
- FSM has two states, CLEAR and RUN.
- CLEAR:
  - Each cycle writes zero to mem[idx] and increments idx.
  - After idx=NREG-1 is written, moves to RUN and sets init_done=1 on the same edge.
  - init_done therefore rises NREG-1 cycles after the first edge with reset=0.
  - we, re and issue_valid are ignored; rdata holds 0; hazard=0.
  - Reset asserted mid-sweep restarts the sweep at index 1.
- RUN, write:
  - If we=1 and waddr!=0: mem[waddr] <= wdata and pending[waddr] <= 0.
  - waddr=0 is ignored.
- RUN, read (latency 1):
  - If re=1, for each port p: rdata_p <= 0 if raddr_p=0.
  - Else rdata_p <= wdata if BYPASS=1 and we=1 and waddr=raddr_p.
  - Else rdata_p <= mem[raddr_p] (old value when BYPASS=0).
  - If re=0, rdata holds its previous value.
- RUN, issue:
  - If issue_valid=1 and issue_rd!=0: pending[issue_rd] <= 1.
  - If an issue and a write target the same register in the same cycle, set wins: the new producer stays outstanding.
  - issue_rd=0 is ignored.
- hazard_p = pending[raddr_p] and not (BYPASS=1 and we=1 and waddr=raddr_p and waddr!=0).
  - hazard_p is 0 for raddr_p=0 and 0 outside RUN.
- Several read ports may name the same register; each gets identical data.
- All arithmetic on indices is unsigned AW-bit; the sweep index never wraps past NREG-1.

Decomposition:
- Shared package regfile_pkg:
  - FSM state enum (RF_CLEAR, RF_RUN).
  - clog2 function.
  - Default XLEN/NREG constants shared with decode and writeback stages.
- One natural sub-module, regfile_scoreboard: pending vector plus hazard logic, parametrised by NREG and NRD.
- Storage array, sweep FSM and read ports stay in regfile_sb.

Test Plan:
- Reset 1 cycle, release, hold re=1 raddr={5,3} -> init_done rises exactly 15 cycles later; rdata=0 throughout; we during CLEAR leaves storage unchanged.
- After init, write x5=0xDEADBEEF, next cycle read raddr={5,0} -> rdata={0xDEADBEEF,0} one cycle after re; write waddr=0 data 0x1234 then read x0 -> 0.
- BYPASS=1: same cycle we=1 waddr=7 wdata=0xA5A5A5A5 and re=1 raddr={7,7} -> both ports 0xA5A5A5A5 next cycle. With BYPASS=0 the same stimulus returns the prior value 0.
- issue_valid rd=9 -> pending[9]=1 and hazard_p=1 for raddr_p=9. Write x9 -> hazard 0 in the same cycle (BYPASS=1) and pending[9]=0 next cycle. Simultaneous issue rd=9 and write x9 -> pending[9] stays 1.
- Reset asserted at sweep idx=6 for 1 cycle -> pending cleared, sweep restarts at 1, init_done rises 15 cycles after release.
- re=0 for 3 cycles after a read of 0x11 while x1 is rewritten to 0x22 -> rdata holds 0x11.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file types and default sizes used by decode, the register file
// and writeback.
package regfile_pkg;

    localparam int RF_XLEN = 32;
    localparam int RF_NREG = 16;

    typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;

    function automatic int rf_clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, plus per-read-port hazard flags.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG   = RF_NREG,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = rf_clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NREG-1:0]   pending,
    output logic [NRD-1:0]    hazard
);

    logic [NREG-1:0] pend_nxt;

    // Issue is applied after writeback so a new producer stays outstanding.
    always_comb begin
        pend_nxt = pending;
        if (run) begin
            if (we && waddr != '0)
                pend_nxt[waddr] = 1'b0;
            if (issue_valid && issue_rd != '0)
                pend_nxt[issue_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) pending <= '0;
        else       pending <= pend_nxt;
    end

    always_comb begin
        hazard = '0;
        for (int p = 0; p < NRD; p++) begin
            logic [AW-1:0] ra;
            logic          fwd;
            ra  = raddr[p*AW +: AW];
            fwd = (BYPASS != 0) && we && (waddr == ra) && (waddr != '0);
            hazard[p] = run && (ra != '0) && pending[ra] && !fwd;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with x0 hard-wired to zero, post-reset clear sweep,
// NRD registered read ports, one write port and an integrated scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREG   = RF_NREG,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = rf_clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    output logic                init_done,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                re,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic [NREG-1:0]     pending,
    output logic [NRD-1:0]      hazard
);

    rf_state_e       state, state_nxt;
    logic [AW-1:0]   idx, idx_nxt;
    logic            init_nxt;
    logic            run;
    logic [XLEN-1:0] mem [NREG];

    assign run = (state == RF_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RF_CLEAR;
            idx       <= AW'(1);
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            init_done <= init_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        init_nxt  = init_done;
        case (state)
            RF_CLEAR: begin
                if (idx == AW'(NREG - 1)) begin
                    state_nxt = RF_RUN;
                    init_nxt  = 1'b1;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            RF_RUN:  init_nxt = 1'b1;
            default: state_nxt = RF_CLEAR;
        endcase
    end

    // Single write port, no reset: the sweep shares it so the array maps to RAM.
    always_ff @(posedge clk) begin
        if (!run)
            mem[idx] <= '0;
        else if (we && waddr != '0)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (run && re) begin
            for (int p = 0; p < NRD; p++) begin
                if (raddr[p*AW +: AW] == '0)
                    rdata[p*XLEN +: XLEN] <= '0;
                else if ((BYPASS != 0) && we && waddr == raddr[p*AW +: AW])
                    rdata[p*XLEN +: XLEN] <= wdata;
                else
                    rdata[p*XLEN +: XLEN] <= mem[raddr[p*AW +: AW]];
            end
        end
    end

    regfile_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .we          (we),
        .waddr       (waddr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .raddr       (raddr),
        .pending     (pending),
        .hazard      (hazard)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one BYPASS=1 and one BYPASS=0 instance on shared inputs.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int NRD  = 2;
    localparam int AW   = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                we, re, issue_valid;
    logic [AW-1:0]       waddr, issue_rd;
    logic [XLEN-1:0]     wdata;
    logic [NRD*AW-1:0]   raddr;
    logic                init_done, init_done0;
    logic [NRD*XLEN-1:0] rdata, rdata0;
    logic [NREG-1:0]     pending, pending0;
    logic [NRD-1:0]      hazard, hazard0;

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .pending(pending), .hazard(hazard)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut0 (
        .clk(clk), .reset(reset), .init_done(init_done0),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata0),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .pending(pending0), .hazard(hazard0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re = 1'b1; raddr = {4'd3, 4'd5}; issue_valid = 1'b0; issue_rd = '0;
        step();
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);

        // Writes during the sweep must be ignored.
        reset = 1'b0; we = 1'b1; waddr = 4'd5; wdata = 32'hFFFF_FFFF;
        cnt = 0;
        while (!init_done && cnt < 40) begin
            chk("clr_hazard", 64'(hazard), 64'd0);
            step();
            cnt++;
            chk("clr_rdata", rdata, 64'd0);
        end
        chk("init_latency", 64'(cnt), 64'd15);
        we = 1'b0;
        step();
        chk("clr_we_ignored", rdata, 64'd0);

        // Write x5, read {x0, x5}
        we = 1'b1; waddr = 4'd5; wdata = 32'hDEAD_BEEF; re = 1'b0;
        step();
        we = 1'b0; re = 1'b1; raddr = {4'd0, 4'd5};
        chk("read_latency", rdata, 64'd0);
        step();
        chk("read_x5", rdata, {32'h0, 32'hDEAD_BEEF});

        // Write to x0 is dropped even with same-cycle read of x0
        we = 1'b1; waddr = 4'd0; wdata = 32'h0000_1234; raddr = {4'd5, 4'd0};
        step();
        chk("x0_write", rdata, {32'hDEAD_BEEF, 32'h0});
        we = 1'b0; raddr = {4'd0, 4'd0};
        step();
        chk("x0_read", rdata, 64'd0);

        // Same-cycle write/read of x7
        we = 1'b1; waddr = 4'd7; wdata = 32'hA5A5_A5A5; raddr = {4'd7, 4'd7};
        step();
        chk("bypass1", rdata, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
        chk("bypass0_old", rdata0, 64'd0);
        we = 1'b0;
        step();
        chk("bypass0_new", rdata0, {32'hA5A5_A5A5, 32'hA5A5_A5A5});

        // Scoreboard
        re = 1'b0; issue_valid = 1'b1; issue_rd = 4'd9;
        step();
        issue_valid = 1'b0;
        chk("issue_pending", 64'(pending), 64'h0200);
        raddr = {4'd3, 4'd9};
        #1;
        chk("hazard_set", 64'(hazard), 64'b01);
        we = 1'b1; waddr = 4'd9; wdata = 32'h99;
        #1;
        chk("hazard_fwd1", 64'(hazard), 64'b00);
        chk("hazard_fwd0", 64'(hazard0), 64'b01);
        step();
        we = 1'b0;
        chk("wb_clear", 64'(pending), 64'd0);

        we = 1'b1; waddr = 4'd9; issue_valid = 1'b1; issue_rd = 4'd9;
        step();
        chk("issue_wins", 64'(pending), 64'h0200);
        issue_rd = 4'd0;
        step();
        we = 1'b0; issue_valid = 1'b0;
        chk("issue_x0", 64'(pending), 64'd0);

        // Read-enable low holds rdata
        we = 1'b1; waddr = 4'd1; wdata = 32'h11; re = 1'b0;
        step();
        we = 1'b0; re = 1'b1; raddr = {4'd1, 4'd1};
        step();
        chk("hold_first", rdata, {32'h11, 32'h11});
        re = 1'b0; we = 1'b1; wdata = 32'h22;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_re0", rdata, {32'h11, 32'h11});
        end
        we = 1'b0; re = 1'b1;
        step();
        chk("hold_reread", rdata, {32'h22, 32'h22});

        // Reset mid-sweep
        issue_valid = 1'b1; issue_rd = 4'd4;
        step();
        issue_valid = 1'b0;
        chk("pre_rst_pending", 64'(pending), 64'h0010);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_pending", 64'(pending), 64'd0);
        for (int i = 0; i < 5; i++) step();
        chk("mid_sweep_init", 64'(init_done), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst3_init_done", 64'(init_done), 64'd0);
        cnt = 0;
        while (!init_done && cnt < 40) begin
            step();
            cnt++;
        end
        chk("restart_latency", 64'(cnt), 64'd15);
        raddr = {4'd7, 4'd1};
        step();
        chk("swept_clear", rdata, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
